// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/stall/flush controller with memory-wait timeout and debug halt
// Ports: clk, rst (async, active-low); id_valid/id_reg1/id_reg2/id_pcsrc decode operands and branch;
//   ex_wreg_*/mem_wreg_* downstream destinations; mem_access/mem_ready data-memory handshake;
//   halt_req/resume debug pulses; pipeline register enables and bubble injects;
//   halted, mem_timeout (sticky), stall_count (saturating).
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_reg1,
  input  logic [4:0]  id_reg2,
  input  logic        id_pcsrc,
  input  logic        ex_wreg_en,
  input  logic [4:0]  ex_wreg_addr,
  input  logic        mem_wreg_en,
  input  logic [4:0]  mem_wreg_addr,
  input  logic        mem_access,
  input  logic        mem_ready,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_write,
  output logic        idex_bubble,
  output logic        exmem_write,
  output logic        memwb_bubble,
  output logic        halted,
  output logic        mem_timeout,
  output logic [15:0] stall_count
);
  localparam logic [1:0] RUN = 2'd0, MEMWAIT = 2'd1, DRAIN = 2'd2, HALTED = 2'd3;
  logic [1:0] state;
  logic [7:0] wcnt;
  logic [1:0] dcnt;
  logic       halt_pend;
  logic       mem_hold;
  logic       raw_hz;
  assign mem_hold = mem_access & ~mem_ready;
  assign raw_hz = id_valid & ((ex_wreg_en & (ex_wreg_addr == id_reg1 | ex_wreg_addr == id_reg2)) |
                              (mem_wreg_en & (mem_wreg_addr == id_reg1 | mem_wreg_addr == id_reg2)));
  assign halted = state == HALTED;
  // A MEMWAIT cycle whose memory has just completed behaves like RUN.
  always_comb begin
    pc_write = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_write = 1'b1;
    idex_bubble = 1'b0;
    exmem_write = 1'b1;
    memwb_bubble = 1'b0;
    if (mem_hold) begin
      pc_write = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      exmem_write = 1'b0;
      memwb_bubble = 1'b1;
    end else if (state == HALTED) begin
      pc_write = 1'b0;
      ifid_write = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      if (state == DRAIN) begin
        pc_write = 1'b0;
        ifid_flush = 1'b1;
      end
      if (raw_hz) begin
        pc_write = 1'b0;
        ifid_write = 1'b0;
        idex_bubble = 1'b1;
      end else if (state != DRAIN) ifid_flush = id_pcsrc;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      wcnt <= 8'd0;
      dcnt <= 2'd0;
      halt_pend <= 1'b0;
      mem_timeout <= 1'b0;
      stall_count <= 16'd0;
    end else begin
      if ((state == RUN || state == MEMWAIT) && !pc_write && stall_count != 16'hffff)
        stall_count <= stall_count + 16'd1;
      case (state)
        RUN:
          if (mem_hold) begin
            state <= MEMWAIT;
            wcnt <= 8'd0;
            halt_pend <= halt_req;
          end else if (halt_req) begin
            state <= DRAIN;
            dcnt <= 2'd0;
          end
        MEMWAIT:
          if (mem_hold) begin
            halt_pend <= halt_pend | halt_req;
            wcnt <= wcnt + 8'd1;
            // The 255th held MEMWAIT cycle gives up on the memory.
            if (wcnt == 8'd254) begin
              mem_timeout <= 1'b1;
              state <= HALTED;
              halt_pend <= 1'b0;
            end
          end else if (halt_pend | halt_req) begin
            state <= DRAIN;
            dcnt <= 2'd0;
            halt_pend <= 1'b0;
          end else state <= RUN;
        DRAIN:
          if (!mem_hold) begin
            dcnt <= dcnt + 2'd1;
            if (dcnt == 2'd2) state <= HALTED;
          end
        default:
          if (resume && !halt_req) state <= RUN;
      endcase
    end
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have inputs id_valid (1), id_reg1 (5), id_reg2 (5), id_pcsrc (1): ID-stage instruction valid, source register addresses, branch-taken from decode.
REQ-004 SHALL have inputs ex_wreg_en (1), ex_wreg_addr (5): destination of the instruction in EX.
REQ-005 SHALL have inputs mem_wreg_en (1), mem_wreg_addr (5), mem_access (1), mem_ready (1): MEM-stage destination, data-memory access active, memory done.
REQ-006 SHALL have inputs halt_req (1), resume (1): single-cycle debug pulses.
REQ-007 SHALL have outputs pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble (1 each): pipeline register enables and bubble injects.
REQ-008 SHALL have outputs halted (1), mem_timeout (1), stall_count (16).

Function
REQ-009 SHALL implement FSM states RUN, MEMWAIT, DRAIN, HALTED; reset state RUN.
REQ-010 SHALL define raw_hz = id_valid & ((ex_wreg_en & (ex_wreg_addr==id_reg1 | ex_wreg_addr==id_reg2)) | (mem_wreg_en & (mem_wreg_addr==id_reg1 | mem_wreg_addr==id_reg2))); register 0 is compared like any other.
REQ-011 SHALL define mem_hold = mem_access & ~mem_ready, combinational, effective in the same cycle.
REQ-012 Priority SHALL be mem_hold > HALTED/DRAIN > raw_hz > id_pcsrc.
REQ-013 mem_hold (any state) SHALL drive pc_write=ifid_write=idex_write=exmem_write=0, memwb_bubble=1, ifid_flush=0, idex_bubble=0.
REQ-014 RUN, no mem_hold, raw_hz=1 SHALL drive pc_write=ifid_write=0, idex_bubble=1, ifid_flush=0; id_pcsrc ignored that cycle.
REQ-015 RUN, no mem_hold, no raw_hz SHALL drive all write enables 1, bubbles 0, ifid_flush=id_pcsrc.
REQ-016 RUN→MEMWAIT SHALL occur on a clock edge with mem_hold=1; MEMWAIT→return state when mem_hold=0 at an edge.
REQ-017 SHALL keep an 8-bit wait counter, cleared on MEMWAIT entry, incremented each MEMWAIT cycle; reaching 255 SHALL set mem_timeout (sticky until reset) and force HALTED.
REQ-018 halt_req in RUN without mem_hold SHALL enter DRAIN next cycle with a 2-bit drain counter at 0; halt_req during mem_hold SHALL be latched and acted on when mem_hold clears.
REQ-019 DRAIN SHALL drive pc_write=0, ifid_flush=1, other enables 1; raw_hz still applies; counter increments per non-held cycle; after 3 increments → HALTED.
REQ-020 HALTED SHALL drive pc_write=ifid_write=0, idex_bubble=1, halted=1; resume → RUN next cycle; halt_req and resume together in HALTED SHALL stay HALTED.
REQ-021 resume outside HALTED and halt_req in DRAIN/HALTED SHALL be ignored.
REQ-022 stall_count SHALL increment each cycle pc_write=0 while in RUN or MEMWAIT, saturating at 0xFFFF.
REQ-023 All outputs SHALL be combinational from state and current inputs; no extra latency.

Reset
REQ-024 rst low SHALL immediately force RUN, all counters 0, latched halt 0, mem_timeout 0, halted 0.
REQ-025 With rst low and inputs idle, outputs SHALL be pc_write=ifid_write=idex_write=exmem_write=1, all others 0.
REQ-026 Reset asserted mid-MEMWAIT or mid-DRAIN SHALL abort the sequence with no residual state.

Verification
REQ-027 EX dest r5 wreg_en=1, ID reg2=5 valid -> pc_write=0, idex_bubble=1 same cycle; stall_count 0→1.
REQ-028 id_pcsrc=1, no hazard -> ifid_flush=1 for one cycle, pc_write=1; with concurrent raw_hz -> ifid_flush=0.
REQ-029 mem_access=1, mem_ready=0 for 4 cycles -> all writes 0, memwb_bubble=1 for 4 cycles, RUN on 5th.
REQ-030 mem_ready held 0 for 300 cycles -> mem_timeout=1 and halted=1 after 255 MEMWAIT cycles.
REQ-031 halt_req pulse -> 3 DRAIN cycles with ifid_flush=1, halted=1 on 4th; resume -> pc_write=1 next cycle.
REQ-032 rst low during DRAIN -> halted=0, state RUN, stall_count 0 asynchronously.
